// File: rtl/qnigma_cks_arb_if.sv
// qnigma_cks_arb_if: requester and checksum-engine signals of the checksum arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the engine.
interface qnigma_cks_arb_if #(
    parameter int unsigned N = 2
);
    // requester side
    logic [N-1:0]       req;
    logic [N-1:0]       gnt;
    logic [N-1:0][31:0] ini;
    logic [N-1:0][7:0]  dat;
    logic [N-1:0]       val;
    logic [N-1:0]       lst;
    logic [N-1:0]       don;
    logic [15:0]        cks;
    logic               zer;
    logic               err;

    // engine side
    logic               eng_rst;
    logic [31:0]        eng_ini;
    logic [7:0]         eng_dat;
    logic               eng_val;
    logic               eng_nxt;
    logic [15:0]        eng_cks;
    logic               eng_zer;

    modport slave (
        input  req, ini, dat, val, lst, eng_cks, eng_zer,
        output gnt, don, cks, zer, err,
        output eng_rst, eng_ini, eng_dat, eng_val, eng_nxt
    );

    modport master (
        output req, ini, dat, val, lst, eng_cks, eng_zer,
        input  gnt, don, cks, zer, err,
        input  eng_rst, eng_ini, eng_dat, eng_val, eng_nxt
    );
endinterface

// File: rtl/qnigma_cks_arb.sv
// qnigma_cks_arb: round-robin sharing of one one's-complement checksum engine
// between N packet builders. Each transaction loads the winner's seed, forwards
// its byte stream, waits the engine latency, then returns the captured result.
// Optional stall abort is enabled by defining QNIGMA_CKS_ARB_TIMEOUT_EN.
module qnigma_cks_arb #(
    parameter int unsigned N   = 2,
    parameter int unsigned LAT = 4,
    parameter int unsigned TMO = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    qnigma_cks_arb_if.slave        bus
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    // Reject parameter sets the datapath cannot represent.
    if (N < 2 || N > 8 || LAT < 1 || TMO < 1 || TMO > 255) begin : g_param_check
        $error("qnigma_cks_arb: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE,
        ABORT
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  ptr, ptr_nxt;
    logic [PW-1:0]  sel, sel_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [N-1:0]   gnt_q, gnt_nxt;
    logic [N-1:0]   don_q, don_nxt;
    logic [15:0]    cks_q, cks_nxt;
    logic           zer_q, zer_nxt;
    logic           sel_val;
    logic           sel_lst;

`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
    logic [7:0]     stall, stall_nxt;
    logic           err_q, err_nxt;
`endif

    // First set request bit at or after the pointer, wrapping modulo N.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] pick;
        logic          found;
        int unsigned   k;
        pick  = p;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(p) + i) % N;
            if (!found && r[PW'(k)]) begin
                pick  = PW'(k);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
        logic [N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (32'(i) == N - 1) ? '0 : i + PW'(1);
    endfunction

    assign sel_val = bus.val[sel];
    assign sel_lst = bus.lst[sel];

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            gnt_q <= '0;
            don_q <= '0;
            cks_q <= 16'h0000;
            zer_q <= 1'b0;
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
            stall <= 8'h00;
            err_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            gnt_q <= gnt_nxt;
            don_q <= don_nxt;
            cks_q <= cks_nxt;
            zer_q <= zer_nxt;
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
            stall <= stall_nxt;
            err_q <= err_nxt;
`endif
        end
    end

    // Next-state and next-output logic for the grant/load/stream/drain/done sequence.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt_q;
        don_nxt   = '0;
        cks_nxt   = cks_q;
        zer_nxt   = zer_q;
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
        stall_nxt = stall;
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    sel_nxt   = rr_pick(bus.req, ptr);
                    gnt_nxt   = onehot(sel_nxt);
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
                stall_nxt = 8'h00;
`endif
                state_nxt = STREAM;
            end
            STREAM: begin
                if (sel_val) begin
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
                    stall_nxt = 8'h00;
`endif
                    if (sel_lst) begin
                        cnt_nxt   = '0;
                        state_nxt = DRAIN;
                    end
                end
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
                else if (stall == 8'(TMO - 1)) begin
                    // Requester stalled too long: drop the grant and re-init the engine.
                    err_nxt   = 1'b1;
                    gnt_nxt   = '0;
                    ptr_nxt   = next_idx(sel);
                    state_nxt = ABORT;
                end else begin
                    stall_nxt = stall + 8'd1;
                end
`endif
            end
            DRAIN: begin
                if (cnt == CW'(LAT - 1)) begin
                    cks_nxt   = bus.eng_cks;
                    zer_nxt   = bus.eng_zer;
                    don_nxt   = onehot(sel);
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                ptr_nxt   = next_idx(sel);
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
            ABORT: begin
                state_nxt = IDLE;
            end
`endif
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt = gnt_q;
    assign bus.don = don_q;
    assign bus.cks = cks_q;
    assign bus.zer = zer_q;

    // Engine drive: seed only during LOAD, bytes only from the granted requester in STREAM.
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
    assign bus.err     = err_q;
    assign bus.eng_rst = rst | (state == LOAD) | (state == ABORT);
`else
    assign bus.err     = 1'b0;
    assign bus.eng_rst = rst | (state == LOAD);
`endif
    assign bus.eng_ini = (state == LOAD) ? bus.ini[sel] : 32'h0000_0000;
    assign bus.eng_dat = (state == STREAM) ? bus.dat[sel] : 8'h00;
    assign bus.eng_val = (state == STREAM) & sel_val & ~rst;
    assign bus.eng_nxt = 1'b0;

endmodule

// File: tb/tb_qnigma_cks_arb.sv
// tb_qnigma_cks_arb: self-checking bench for qnigma_cks_arb with a behavioural
// checksum engine whose result appears exactly LAT cycles after the last byte.
module tb_qnigma_cks_arb;

    localparam int unsigned N   = 3;
    localparam int unsigned LAT = 4;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    qnigma_cks_arb_if #(.N(N)) bus ();

    qnigma_cks_arb #(.N(N), .LAT(LAT), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural checksum engine ----------------
    logic [31:0] acc;
    logic        hi_byte;
    logic [15:0] pipe [LAT-1];

    function automatic logic [15:0] fold16(input logic [31:0] s);
        logic [31:0] t;
        t = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        t = {16'h0, t[31:16]} + {16'h0, t[15:0]};
        return t[15:0];
    endfunction

    // Accumulate big-endian 16-bit words; result delayed so it is valid LAT cycles after the last byte.
    always @(posedge clk) begin
        if (bus.eng_rst) begin
            acc     <= bus.eng_ini;
            hi_byte <= 1'b1;
        end else if (bus.eng_val) begin
            acc     <= acc + (hi_byte ? {16'h0, bus.eng_dat, 8'h00} : {24'h0, bus.eng_dat});
            hi_byte <= ~hi_byte;
        end
        pipe[0] <= ~fold16(acc);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.eng_cks = pipe[LAT-2];
    assign bus.eng_zer = (pipe[LAT-2] == 16'h0000);

    // ---------------- scoreboard and bookkeeping ----------------
    typedef struct {
        int          idx;
        logic [15:0] cks;
        logic        zer;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  tx_bytes[$];
    logic        bg_val      = 1'b0;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    function automatic logic [15:0] ref_cks(input logic [31:0] seed, input logic [7:0] b[$]);
        logic [31:0] s;
        s = {16'h0, seed[31:16]} + {16'h0, seed[15:0]};
        for (int i = 0; i < b.size(); i++)
            s = s + ((i % 2 == 0) ? {16'h0, b[i], 8'h00} : {24'h0, b[i]});
        return ~fold16(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int exp_idx);
        int n;
        n = 0;
        while (bus.gnt == '0 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.gnt !== onehot(exp_idx)) begin
            miscompares++;
            $display("FAIL wait_gnt: gnt=%b required %b (waited %0d cycles)", bus.gnt, onehot(exp_idx), n);
        end
    endtask

    // Called in the LOAD cycle; streams tx_bytes and checks the done pulse and result.
    task automatic do_stream(input int idx, input logic [31:0] seed, input int stall_after,
                             input int stall_len, input logic [15:0] exp_cks, input logic exp_zer);
        exp_t e;
        int   nb;
        nb = tx_bytes.size();
        vectors++;
        if (bus.eng_rst !== 1'b1 || bus.eng_ini !== seed) begin
            miscompares++;
            $display("FAIL load: eng_rst=%b eng_ini=%h required 1 %h", bus.eng_rst, bus.eng_ini, seed);
        end
        e.idx = idx;
        e.cks = exp_cks;
        e.zer = exp_zer;
        sb.push_back(e);
        tick();
        vectors++;
        if (bus.eng_rst !== 1'b0 || bus.eng_ini !== 32'h0) begin
            miscompares++;
            $display("FAIL stream_entry: eng_rst=%b eng_ini=%h required 0 00000000", bus.eng_rst, bus.eng_ini);
        end
        for (int i = 0; i < nb; i++) begin
            bus.dat[idx] = tx_bytes[i];
            bus.val[idx] = 1'b1;
            bus.lst[idx] = (i == nb - 1);
            #1;
            vectors++;
            if (bus.eng_val !== 1'b1 || bus.eng_dat !== tx_bytes[i]) begin
                miscompares++;
                $display("FAIL byte%0d: eng_val=%b eng_dat=%h required 1 %h", i, bus.eng_val, bus.eng_dat, tx_bytes[i]);
            end
            tick();
            if (i == stall_after) begin
                bus.val[idx] = 1'b0;
                bus.lst[idx] = 1'b0;
                repeat (stall_len) tick();
                vectors++;
                if (bus.gnt !== onehot(idx) || bus.err !== 1'b0 || bus.don !== '0 || bus.eng_val !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_wait: gnt=%b err=%b don=%b eng_val=%b required %b 0 000 0",
                             bus.gnt, bus.err, bus.don, bus.eng_val, onehot(idx));
                end
            end
        end
        bus.val[idx] = bg_val;
        bus.lst[idx] = bg_val;
        bus.dat[idx] = 8'hEE;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT) begin
                vectors++;
                if (bus.don !== '0 || bus.eng_val !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drain%0d: don=%b eng_val=%b required 000 0", k, bus.don, bus.eng_val);
                end
            end
        end
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: queue empty at done");
        end else begin
            e = sb.pop_front();
            vectors++;
            if (bus.don !== onehot(e.idx) || bus.gnt !== onehot(e.idx)) begin
                miscompares++;
                $display("FAIL don: don=%b gnt=%b required %b", bus.don, bus.gnt, onehot(e.idx));
            end
            vectors++;
            if (bus.cks !== e.cks || bus.zer !== e.zer) begin
                miscompares++;
                $display("FAIL result: cks=%h zer=%b required %h %b", bus.cks, bus.zer, e.cks, e.zer);
            end
        end
    endtask

    task automatic run_txn(input int idx, input logic [31:0] seed, input logic [15:0] exp_cks, input logic exp_zer);
        bus.ini[idx] = seed;
        bus.req[idx] = 1'b1;
        wait_gnt(idx);
        do_stream(idx, seed, -1, 0, exp_cks, exp_zer);
        bus.req[idx] = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.val = '0;
        bus.lst = '0;
        bus.dat = '0;
        bus.ini = '0;
        repeat (3) tick();
        vectors++;
        if (bus.gnt !== '0 || bus.don !== '0 || bus.cks !== 16'h0 || bus.zer !== 1'b0 ||
            bus.err !== 1'b0 || bus.eng_val !== 1'b0 || bus.eng_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: gnt=%b don=%b cks=%h zer=%b err=%b eng_val=%b eng_rst=%b required 000 000 0000 0 0 0 1",
                     bus.gnt, bus.don, bus.cks, bus.zer, bus.err, bus.eng_val, bus.eng_rst);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.eng_rst !== 1'b0 || bus.gnt !== '0) begin
            miscompares++;
            $display("FAIL reset_release: eng_rst=%b gnt=%b required 0 000", bus.eng_rst, bus.gnt);
        end
    endtask

    task automatic test_arbitration();
        int ord[4] = '{0, 1, 2, 0};
        logic [15:0] c;
        bg_val  = 1'b1;
        bus.val = '1;
        bus.lst = '1;
        for (int i = 0; i < N; i++) bus.dat[i] = 8'hEE;
        bus.ini = '0;
        bus.req = '1;
        wait_gnt(0);
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                tick();
                vectors++;
                if (bus.gnt !== '0) begin
                    miscompares++;
                    $display("FAIL arb_idle%0d: gnt=%b required 000", g, bus.gnt);
                end
                tick();
                vectors++;
                if (bus.gnt !== onehot(ord[g])) begin
                    miscompares++;
                    $display("FAIL arb_order%0d: gnt=%b required %b", g, bus.gnt, onehot(ord[g]));
                end
            end
            tx_bytes = '{8'(8'h10 * (ord[g] + 1) + g), 8'h5A};
            c = ref_cks(32'h0, tx_bytes);
            do_stream(ord[g], 32'h0, -1, 0, c, (c == 16'h0));
        end
        bus.req = '0;
        bg_val  = 1'b0;
        bus.val = '0;
        bus.lst = '0;
        tick();
    endtask

    task automatic test_basic();
        bus.ini[0] = 32'h0;
        bus.req[0] = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== 3'b001) begin
            miscompares++;
            $display("FAIL grant_latency: gnt=%b required 001", bus.gnt);
        end
        tx_bytes = '{8'h45, 8'h00, 8'h00, 8'h1c};
        do_stream(0, 32'h0, -1, 0, 16'hBAE3, 1'b0);
        bus.req[0] = 1'b0;
        tick();
    endtask

    task automatic test_odd();
        tx_bytes = '{8'h01, 8'h02, 8'h03};
        run_txn(1, 32'h0, 16'hFBFD, 1'b0);
    endtask

    task automatic test_seed();
        tx_bytes = '{8'h00, 8'h00};
        run_txn(2, 32'h0001_FFFF, 16'hFFFE, 1'b0);
    endtask

    task automatic test_zero();
        tx_bytes = '{8'hFF, 8'hFF};
        run_txn(0, 32'h0, 16'h0000, 1'b1);
    endtask

    task automatic test_back_to_back();
        bus.ini[1] = 32'h0;
        bus.req[1] = 1'b1;
        wait_gnt(1);
        tx_bytes = '{8'h12, 8'h34};
        do_stream(1, 32'h0, -1, 0, 16'hEDCB, 1'b0);
        bus.req[1] = 1'b0;
        bus.ini[2] = 32'h0;
        bus.req[2] = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== '0) begin
            miscompares++;
            $display("FAIL b2b_idle: gnt=%b required 000", bus.gnt);
        end
        tick();
        vectors++;
        if (bus.gnt !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_grant: gnt=%b required 100", bus.gnt);
        end
        tx_bytes = '{8'hAB};
        do_stream(2, 32'h0, -1, 0, 16'h54FF, 1'b0);
        bus.req[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen_don;
        bus.ini[0] = 32'h0;
        bus.req[0] = 1'b1;
        wait_gnt(0);
        tick();
        bus.dat[0] = 8'h45; bus.val[0] = 1'b1; bus.lst[0] = 1'b0;
        tick();
        bus.dat[0] = 8'h00;
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== '0 || bus.don !== '0 || bus.cks !== 16'h0 || bus.zer !== 1'b0 || bus.eng_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: gnt=%b don=%b cks=%h zer=%b eng_rst=%b required 000 000 0000 0 1",
                     bus.gnt, bus.don, bus.cks, bus.zer, bus.eng_rst);
        end
        rst        = 1'b0;
        bus.val[0] = 1'b0;
        bus.req[0] = 1'b0;
        seen_don   = 1'b0;
        repeat (LAT + 2) begin
            tick();
            if (bus.don !== '0) seen_don = 1'b1;
        end
        vectors++;
        if (seen_don !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_don: don seen=%b required 0", seen_don);
        end
        tx_bytes = '{8'h45, 8'h00, 8'h00, 8'h1c};
        run_txn(0, 32'h0, 16'hBAE3, 1'b0);
    endtask

    task automatic test_stall();
        bus.ini[1] = 32'h0;
        bus.req[1] = 1'b1;
        wait_gnt(1);
`ifdef QNIGMA_CKS_ARB_TIMEOUT_EN
        tick();
        bus.dat[1] = 8'hAB; bus.val[1] = 1'b1; bus.lst[1] = 1'b0;
        tick();
        bus.val[1] = 1'b0;
        for (int j = 1; j <= TMO; j++) begin
            tick();
            vectors++;
            if (j < TMO) begin
                if (bus.err !== 1'b0 || bus.gnt !== 3'b010) begin
                    miscompares++;
                    $display("FAIL stall%0d: err=%b gnt=%b required 0 010", j, bus.err, bus.gnt);
                end
            end else if (bus.err !== 1'b1 || bus.gnt !== '0 || bus.don !== '0 ||
                         bus.eng_rst !== 1'b1 || bus.cks !== 16'hBAE3) begin
                miscompares++;
                $display("FAIL abort: err=%b gnt=%b don=%b eng_rst=%b cks=%h required 1 000 000 1 bae3",
                         bus.err, bus.gnt, bus.don, bus.eng_rst, bus.cks);
            end
        end
        bus.ini[2] = 32'h0;
        bus.req[2] = 1'b1;
        tick();
        vectors++;
        if (bus.err !== 1'b0 || bus.gnt !== '0) begin
            miscompares++;
            $display("FAIL abort_idle: err=%b gnt=%b required 0 000", bus.err, bus.gnt);
        end
        wait_gnt(2);
        bus.req[1] = 1'b0;
        tx_bytes = '{8'h12, 8'h34};
        do_stream(2, 32'h0, -1, 0, 16'hEDCB, 1'b0);
        bus.req[2] = 1'b0;
        tick();
`else
        tx_bytes = '{8'hAB, 8'hCD};
        do_stream(1, 32'h0, 0, TMO + 4, 16'h5432, 1'b0);
        bus.req[1] = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_basic();
        test_odd();
        test_seed();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qnigma_cks_arb.md
# qnigma_cks_arb

Round-robin arbiter and sequencer that shares one one's-complement checksum engine between N packet builders (for example the ICMPv6, UDP and TCP transmit paths) in the network stack. Each transaction runs in three steps:
- the granted requester's 32-bit pseudo-header seed is loaded into the engine;
- the requester's byte stream is forwarded to the engine;
- after the engine's fixed pipeline latency, the 16-bit result and zero flag are captured and returned to that requester with a done pulse.

## Interface
Parameters:
- N, 2: number of requesters (2..8).
- LAT, 4: cycles from the last accepted byte until engine checksum and zero flag are both valid.
- TMO, 255: stall limit in cycles (used only with the timeout feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  N  transaction request, one bit per requester; level signal, held until don.
- gnt  out  N  one-hot grant; high from LOAD through DONE.
- ini  in  N×32  per-requester seed (pseudo-header partial sum).
- dat  in  N×8  per-requester byte.
- val  in  N  byte valid.
- lst  in  N  last byte; meaningful only with val.
- don  out  N  one-cycle completion pulse to the granted requester.
- cks  out  16  captured checksum; held until the next DONE.
- zer  out  1  captured engine zero flag; held with cks.
- err  out  1  stall abort pulse (only with QNIGMA_CKS_ARB_TIMEOUT_EN).
- eng_rst  out  1  engine init/seed load.
- eng_ini  out  32  engine seed.
- eng_dat  out  8  engine byte.
- eng_val  out  1  engine byte valid.
- eng_nxt  out  1  engine flush select; tied 0.
- eng_cks  in  16  engine checksum.
- eng_zer  in  1  engine zero flag.

## Operation
State machine states: IDLE, LOAD, STREAM, DRAIN, DONE.

- **IDLE**
  - If any req bit is set, select the first set bit at or after ptr, wrapping modulo N.
  - Register the selected index as sel, set gnt[sel], and go to LOAD.
- **LOAD** (1 cycle)
  - eng_rst=1 and eng_ini=ini[sel]; then go to STREAM.
- **STREAM**
  - eng_dat=dat[sel] and eng_val=val[sel], both combinational.
  - Other requesters' val/lst are ignored.
  - val[sel]&lst[sel] accepts the final byte, clears the drain counter and moves to DRAIN.
- **DRAIN**
  - Count LAT cycles.
  - In the last DRAIN cycle, register cks<=eng_cks and zer<=eng_zer, then go to DONE.
- **DONE** (1 cycle)
  - don[sel]=1, ptr<=sel+1 mod N, clear gnt, return to IDLE.

Common rules:
- eng_rst = rst | (state==LOAD).
- eng_val=0 outside STREAM.
- eng_ini=0 outside LOAD.
- Requester behaviour in the handshake:
  - dropping req mid-transaction is ignored; the grant is held until DONE;
  - req newly raised by others waits for IDLE;
  - odd byte counts need no controller action, because the engine pads internally.
- Zero-length transfers are unsupported: the transaction ends only on lst with val.

## Timing
- Reset values:
  - state IDLE, gnt=0, don=0, cks=16'h0000, zer=0, err=0, ptr=0, eng_val=0;
  - eng_rst=1 while rst is high.
- Reset mid-transaction aborts immediately. No don is issued, cks/zer are cleared and the engine is re-initialised.
- Latency, for req rising at cycle 0 in IDLE:
  - gnt and LOAD at cycle 1;
  - STREAM from cycle 2, so the first byte can be accepted at cycle 2;
  - last byte at cycle T gives DRAIN at T+1..T+LAT, and don and valid cks at T+LAT+1.
- Back-to-back: a new grant can issue at T+LAT+3 (DONE, then IDLE, then LOAD).
- Arbitration fairness: with all requesters continuously requesting, grants rotate 0,1,…,N-1,0.
- Simultaneous events:
  - a requester whose req rises in the same cycle as DONE is considered in the following IDLE cycle;
  - lst in the first STREAM cycle is legal (1-byte transfer).

## Configuration
- QNIGMA_CKS_ARB_TIMEOUT_EN defined:
  - an 8-bit stall counter increments on each STREAM cycle without val[sel] and clears on val[sel];
  - when the count reaches TMO: one-cycle err pulse, gnt cleared, no don, cks/zer unchanged, ptr advanced, engine re-initialised through one eng_rst cycle, return to IDLE.
- Not defined: err is tied 0, no counter is built, and STREAM waits indefinitely.

## Test plan
- Requester 0, ini=0, bytes 45 00 00 1c with lst on 1c -> don[0] at T+LAT+1, cks=16'hBAE3, zer=0.
- Odd length: requester 1, ini=0, bytes 01 02 03 -> cks=16'hFBFD.
- Seed: ini=32'h0001_FFFF, bytes 00 00 -> cks=~(16'hFFFF+16'h0001 with end-around carry)=16'hFFFE; confirms eng_ini is driven only in LOAD.
- Arbitration: N=3, all req held high, each sends 2 bytes -> grant order 0,1,2,0; only the granted requester's bytes reach eng_dat; don pulses go to the matching index.
- rst asserted mid-STREAM, after 2 of 4 bytes -> next cycle gnt=0, no don, cks=0; a following transaction gives the correct checksum.
- With QNIGMA_CKS_ARB_TIMEOUT_EN, TMO=16: val is stalled 16 cycles in STREAM -> err pulses once, gnt clears, cks keeps its previous value; without the macro the same stimulus leaves the block waiting in STREAM.
